// File: rtl/rgb_channel_scheduler.sv
// Converts an interleaved RGB pixel stream into channel-serial samples by driving
// a shared single-channel extractor once per enabled channel, in R, G, B order.
module rgb_channel_scheduler #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_r,
    input  logic [DATA_W-1:0]             s_g,
    input  logic [DATA_W-1:0]             s_b,
    input  logic [2:0]                    chan_en,
    output logic [DATA_W-1:0]             ext_r,
    output logic [DATA_W-1:0]             ext_g,
    output logic [DATA_W-1:0]             ext_b,
    output logic                          ext_data_valid,
    output logic [1:0]                    ext_channel_select,
    input  logic [DATA_W-1:0]             ext_channel_out,
    input  logic                          ext_data_out_valid,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [1:0]                    m_chan,
    output logic                          m_last,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = 3 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Input pixel FIFO
    logic [PW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] count_reg;
    logic          push;
    logic          pop;
    logic          full;

    state_t            state_reg;
    logic [PW-1:0]     pixel_reg;
    logic [2:0]        mask_reg;
    logic [1:0]        sel_reg;
    logic [CW-1:0]     tmo_cnt_reg;
    logic              ext_data_valid_reg;
    logic              m_valid_reg;
    logic [DATA_W-1:0] m_data_reg;
    logic [1:0]        m_chan_reg;
    logic              m_last_reg;
    logic              timeout_err_reg;

    logic [3:0]        higher_en;
    logic              has_next;
    logic [1:0]        next_sel;
    logic [1:0]        first_sel;
    logic              tmo_hit;

    assign full    = (count_reg == LW'(FIFO_DEPTH));
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign pop     = (state_reg == IDLE) && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s_r, s_g, s_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // higher_en[c]: some channel above c is enabled for the current pixel
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_higher
            assign higher_en[gi] = |(mask_reg & (3'b111 << (gi + 1)));
        end
    endgenerate
    assign higher_en[3] = 1'b0;

    assign has_next = higher_en[sel_reg];
    assign next_sel = ((sel_reg == 2'd0) && mask_reg[1]) ? 2'd1 : 2'd2;

    always_comb begin
        first_sel = 2'd2;
        if (chan_en[0]) begin
            first_sel = 2'd0;
        end else if (chan_en[1]) begin
            first_sel = 2'd1;
        end
    end

    assign tmo_hit = (state_reg == WAIT) && !ext_data_out_valid &&
                     (tmo_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            pixel_reg          <= '0;
            mask_reg           <= '0;
            sel_reg            <= '0;
            tmo_cnt_reg        <= '0;
            ext_data_valid_reg <= 1'b0;
            m_valid_reg        <= 1'b0;
            m_data_reg         <= '0;
            m_chan_reg         <= '0;
            m_last_reg         <= 1'b0;
            timeout_err_reg    <= 1'b0;
        end else begin
            ext_data_valid_reg <= 1'b0;
            if (tmo_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        pixel_reg <= mem[rd_ptr_reg];
                        mask_reg  <= chan_en;
                        // An all-zero mask consumes the pixel without touching the extractor
                        if (chan_en != 3'b000) begin
                            sel_reg            <= first_sel;
                            ext_data_valid_reg <= 1'b1;
                            state_reg          <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (ext_data_out_valid) begin
                        m_data_reg  <= ext_channel_out;
                        m_chan_reg  <= sel_reg;
                        m_last_reg  <= !has_next;
                        m_valid_reg <= 1'b1;
                        state_reg   <= OUT;
                    end else if (tmo_hit) begin
                        // Abandon this channel silently and move on
                        if (has_next) begin
                            sel_reg            <= next_sel;
                            ext_data_valid_reg <= 1'b1;
                            state_reg          <= ISSUE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        if (has_next) begin
                            sel_reg            <= next_sel;
                            ext_data_valid_reg <= 1'b1;
                            state_reg          <= ISSUE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ext_r              = pixel_reg[PW-1 -: DATA_W];
    assign ext_g              = pixel_reg[2*DATA_W-1 -: DATA_W];
    assign ext_b              = pixel_reg[DATA_W-1:0];
    assign ext_data_valid     = ext_data_valid_reg;
    assign ext_channel_select = sel_reg;
    assign m_valid            = m_valid_reg;
    assign m_data             = m_data_reg;
    assign m_chan             = m_chan_reg;
    assign m_last             = m_last_reg;
    assign busy               = (state_reg != IDLE) || (count_reg != '0);
    assign fifo_level         = count_reg;
    assign timeout_err        = timeout_err_reg;

endmodule

// File: tb/tb_rgb_channel_scheduler.sv
// Directed bench for rgb_channel_scheduler with a 2-cycle extractor model.
module tb_rgb_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_r = '0, s_g = '0, s_b = '0;
    logic [2:0] chan_en = '0;
    logic [7:0] ext_r, ext_g, ext_b;
    logic       ext_data_valid;
    logic [1:0] ext_channel_select;
    logic [7:0] ext_channel_out = '0;
    logic       ext_data_out_valid = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] m_chan;
    logic       m_last;
    logic       busy;
    logic [2:0] fifo_level;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    rgb_channel_scheduler #(.DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .chan_en(chan_en),
        .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
        .ext_data_valid(ext_data_valid), .ext_channel_select(ext_channel_select),
        .ext_channel_out(ext_channel_out), .ext_data_out_valid(ext_data_out_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
        .busy(busy), .fifo_level(fifo_level), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    // Extractor model: answers a request two cycles later; can be muted on channel 1
    logic       mute_ch1 = 1'b0;
    logic       pend_v = 1'b0, fire_v = 1'b0;
    logic [7:0] pend_d = '0, fire_d = '0;
    always @(posedge clk) begin
        fire_v = pend_v;
        fire_d = pend_d;
        pend_v = ext_data_valid && !(mute_ch1 && ext_channel_select == 2'd1);
        pend_d = (ext_channel_select == 2'd0) ? ext_r :
                 (ext_channel_select == 2'd1) ? ext_g : ext_b;
        #1;
        ext_data_out_valid = fire_v;
        ext_channel_out    = fire_v ? fire_d : 8'h00;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] chan;
        logic       last;
        int         cyc;
    } out_t;
    out_t got[$];
    int issue_cnt = 0;
    always @(negedge clk) begin
        if (m_valid && m_ready) got.push_back('{data: m_data, chan: m_chan, last: m_last, cyc: cyc});
        if (ext_data_valid) issue_cnt++;
    end

    int n_vec = 0;
    int n_fail = 0;
    int last_push_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int t = 0;
        s_valid = 1'b1; s_r = r; s_g = g; s_b = b;
        while (!s_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("push accept bound", 32'(t), 32'd0);
        last_push_cyc = cyc;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 400) begin
            tick();
            t++;
        end
        if (t >= 400) check({name, " idle bound"}, 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    // Per-pixel vectors: outputs packed first-to-last; cy holds expected cycles, 0 = unchecked
    typedef struct {
        logic [7:0]  r, g, b;
        logic [2:0]  en;
        int          n;
        logic [23:0] d;
        logic [5:0]  ch;
        logic [23:0] cy;
    } vec_t;
    localparam int NV = 7;
    vec_t vt[NV];

    logic [23:0] px3 [6];

    initial begin
        int c0;
        int ic;
        int t;

        vt[0] = '{8'h11, 8'h22, 8'h33, 3'b111, 3, 24'h112233, 6'b00_01_10, {8'd5, 8'd9, 8'd13}};
        vt[1] = '{8'h11, 8'h22, 8'h33, 3'b101, 2, 24'h113300, 6'b00_10_00, 24'h0};
        vt[2] = '{8'h11, 8'h22, 8'h33, 3'b000, 0, 24'h000000, 6'b00_00_00, 24'h0};
        vt[3] = '{8'hA5, 8'h5A, 8'hFF, 3'b010, 1, 24'h5A0000, 6'b01_00_00, 24'h0};
        vt[4] = '{8'h00, 8'h80, 8'h7F, 3'b100, 1, 24'h7F0000, 6'b10_00_00, 24'h0};
        vt[5] = '{8'hDE, 8'hAD, 8'hBE, 3'b011, 2, 24'hDEAD00, 6'b00_01_00, 24'h0};
        vt[6] = '{8'h01, 8'h02, 8'h03, 3'b110, 2, 24'h020300, 6'b01_10_00, {8'd5, 8'd9, 8'd0}};
        px3 = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0, 24'hD0E0F0, 24'h0F1E2D};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("reset s_ready", 32'(s_ready), 32'd1);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset ext_data_valid", 32'(ext_data_valid), 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);

        // Table-driven single-pixel vectors
        m_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            got.delete();
            chan_en = vt[i].en;
            push(vt[i].r, vt[i].g, vt[i].b);
            c0 = last_push_cyc;
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d output count", i), 32'(got.size()), 32'(vt[i].n));
            for (int k = 0; k < vt[i].n && k < got.size(); k++) begin
                check($sformatf("v%0d out%0d data", i, k), 32'(got[k].data), 32'(vt[i].d[23-8*k -: 8]));
                check($sformatf("v%0d out%0d chan", i, k), 32'(got[k].chan), 32'(vt[i].ch[5-2*k -: 2]));
                check($sformatf("v%0d out%0d last", i, k), 32'(got[k].last), 32'(k == vt[i].n - 1));
                if (vt[i].cy[23-8*k -: 8] != 8'd0)
                    check($sformatf("v%0d out%0d cycle", i, k), 32'(got[k].cyc - c0), 32'(vt[i].cy[23-8*k -: 8]));
            end
        end

        // Output held under backpressure, no further extract requests
        got.delete();
        m_ready = 1'b0;
        chan_en = 3'b111;
        push(8'h44, 8'h55, 8'h66);
        t = 0;
        while (!m_valid && t < 50) begin tick(); t++; end
        check("hold m_valid rise", 32'(m_valid), 32'd1);
        ic = issue_cnt;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold%0d m_valid", k), 32'(m_valid), 32'd1);
            check($sformatf("hold%0d m_data", k), 32'(m_data), 32'h44);
            check($sformatf("hold%0d m_chan", k), 32'(m_chan), 32'd0);
            check($sformatf("hold%0d m_last", k), 32'(m_last), 32'd0);
            tick();
        end
        check("hold no new request", 32'(issue_cnt), 32'(ic));
        m_ready = 1'b1;
        wait_idle("hold");
        check("hold output count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("hold out2 data", 32'(got[2].data), 32'h66);
            check("hold out2 last", 32'(got[2].last), 32'd1);
        end

        // FIFO fill under backpressure, then drain in order
        got.delete();
        m_ready = 1'b0;
        for (int p = 0; p < 5; p++) push(px3[p][23:16], px3[p][15:8], px3[p][7:0]);
        check("fill fifo_level", 32'(fifo_level), 32'd4);
        check("fill s_ready", 32'(s_ready), 32'd0);
        check("fill busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        push(px3[5][23:16], px3[5][15:8], px3[5][7:0]);
        wait_idle("fill");
        check("fill output count", 32'(got.size()), 32'd18);
        for (int k = 0; k < 18 && k < got.size(); k++) begin
            check($sformatf("fill out%0d data", k), 32'(got[k].data), 32'(px3[k/3][23-8*(k%3) -: 8]));
            check($sformatf("fill out%0d chan", k), 32'(got[k].chan), 32'(k % 3));
            check($sformatf("fill out%0d last", k), 32'(got[k].last), 32'((k % 3) == 2));
        end

        // Extractor silent on G: timeout after 15 WAIT cycles, B issued next
        got.delete();
        mute_ch1 = 1'b1;
        chan_en = 3'b111;
        push(8'h11, 8'h22, 8'h33);
        c0 = last_push_cyc;
        while (cyc < c0 + 21) tick();
        check("tmo flag before limit", 32'(timeout_err), 32'd0);
        tick();
        check("tmo flag at limit", 32'(timeout_err), 32'd1);
        check("tmo next request", 32'(ext_data_valid), 32'd1);
        check("tmo next select", 32'(ext_channel_select), 32'd2);
        wait_idle("tmo");
        mute_ch1 = 1'b0;
        check("tmo output count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("tmo out0 data", 32'(got[0].data), 32'h11);
            check("tmo out1 data", 32'(got[1].data), 32'h33);
            check("tmo out1 chan", 32'(got[1].chan), 32'd2);
            check("tmo out1 last", 32'(got[1].last), 32'd1);
            check("tmo out1 cycle", 32'(got[1].cyc - c0), 32'd25);
        end
        check("tmo flag sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo flag cleared", 32'(timeout_err), 32'd0);

        // Reset while waiting on the extractor, stale response arrives afterwards
        got.delete();
        push(8'hC1, 8'hC2, 8'hC3);
        push(8'hD1, 8'hD2, 8'hD3);
        t = 0;
        while (!ext_data_valid && t < 50) begin tick(); t++; end
        check("rst request seen", 32'(ext_data_valid), 32'd1);
        tick();
        check("rst fifo_level before", 32'(fifo_level), 32'd1);
        ic = issue_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst ext_data_valid", 32'(ext_data_valid), 32'd0);
        check("rst fifo_level", 32'(fifo_level), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd1);
        check("rst ext_r", 32'(ext_r), 32'd0);
        check("rst select", 32'(ext_channel_select), 32'd0);
        repeat (6) tick();
        check("rst stale m_valid", 32'(m_valid), 32'd0);
        check("rst stale busy", 32'(busy), 32'd0);
        check("rst stale outputs", 32'(got.size()), 32'd0);
        check("rst stale requests", 32'(issue_cnt), 32'(ic));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
